multi_buffer_manager: RTL and testbench

//   Parametrised N-buffer swap manager between the S2MM writer and the MM2S/CPU reader, generalising the fixed 4-buffer scheme.

---
 rtl/multi_buffer_manager.sv | 246 ++++++++++++++++++++++++
 tb/tb_multi_buffer_manager.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_buffer_manager.sv
// N-buffer swap manager between an S2MM writer and an MM2S/CPU reader.
// Each buffer carries a role (FREE, WRITE, PENDING, READ) and PENDING buffers
// carry an age so the reader can take either the newest (LATEST mode) or the
// oldest (QUEUE mode) completed frame. Buffers overwritten before being read
// are counted in a saturating drop counter.
//
// Request/ack handshake: SM_request is a level; only its rising edge (against
// a registered copy of the previous level) is acted on. Exactly one cycle
// after that edge SM_ack pulses high for one cycle, with SM_fresh=1 when a
// PENDING buffer was handed over and SM_fresh=0 when the READ buffer was kept.
// A request held high produces no further acks.
module multi_buffer_manager #(
  parameter int MM_ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_BUFFERS    = 4,
  parameter int MAX_LOG_LENGTH = 22,
  parameter int DROP_WIDTH     = 16
) (
  input  logic                             SYS_aclk,
  input  logic                             SYS_areset,
  input  logic                             SM_clear,
  input  logic                             SM_mode,
  input  logic [4:0]                       SM_log_length,
  input  logic [MM_ADDR_WIDTH-1:0]         SM_base_address,
  input  logic                             SM_request,
  input  logic                             WR_beat,
  output logic                             SM_ack,
  output logic                             SM_fresh,
  output logic [$clog2(NUM_BUFFERS)-1:0]   SM_read_index,
  output logic [MM_ADDR_WIDTH-1:0]         SM_read_buffer,
  output logic [MM_ADDR_WIDTH-1:0]         SM_write_address,
  output logic [$clog2(NUM_BUFFERS):0]     SM_pending_count,
  output logic [DROP_WIDTH-1:0]            SM_drop_count
);

  localparam int IDX_W  = $clog2(NUM_BUFFERS);
  localparam int CNT_W  = IDX_W + 1;
  localparam int AGE_W  = CNT_W;
  localparam int BSHIFT = $clog2(DATA_WIDTH / 8);
  localparam int LEN_W  = MAX_LOG_LENGTH + 1;

  typedef enum logic [1:0] {
    ROLE_FREE    = 2'd0,
    ROLE_WRITE   = 2'd1,
    ROLE_PENDING = 2'd2,
    ROLE_READ    = 2'd3
  } role_t;

  role_t                     role_q   [NUM_BUFFERS];
  role_t                     role_d   [NUM_BUFFERS];
  logic [AGE_W-1:0]          age_q    [NUM_BUFFERS];
  logic [AGE_W-1:0]          age_d    [NUM_BUFFERS];
  logic [IDX_W-1:0]          read_idx_q, read_idx_d;
  logic [IDX_W-1:0]          write_idx_q, write_idx_d;
  logic [MAX_LOG_LENGTH-1:0] wr_count_q, wr_count_d;
  logic [DROP_WIDTH-1:0]     drop_q, drop_d;
  logic                      req_q, req_d;
  logic                      ack_q, ack_d;
  logic                      fresh_q, fresh_d;

  logic [4:0]                eff_log;
  logic [LEN_W-1:0]          len_m1;
  logic                      wr_last;
  logic                      req_edge;
  logic [5:0]                buf_shift;

  logic                      sel_found;
  logic [IDX_W-1:0]          sel_idx;
  logic [AGE_W-1:0]          sel_age;
  logic                      free_found;
  logic [IDX_W-1:0]          free_idx;
  logic                      old_found;
  logic [IDX_W-1:0]          old_idx;
  logic [AGE_W-1:0]          old_age;
  logic [CNT_W-1:0]          drop_inc;
  logic [DROP_WIDTH:0]       drop_sum;
  logic [CNT_W-1:0]          pend_cnt;

  // Role each buffer takes after reset or SM_clear.
  function automatic role_t reset_role(input int i);
    if (i == 0)      return ROLE_READ;
    else if (i == 1) return ROLE_WRITE;
    else             return ROLE_FREE;
  endfunction

  // Buffer length and completion detect; out-of-range lengths clamp to the largest legal one.
  always_comb begin
    eff_log   = (SM_log_length > 5'(MAX_LOG_LENGTH)) ? 5'(MAX_LOG_LENGTH) : SM_log_length;
    len_m1    = (LEN_W'(1) << eff_log) - LEN_W'(1);
    wr_last   = ({1'b0, wr_count_q} >= len_m1);
    req_edge  = SM_request & ~req_q;
    buf_shift = {1'b0, eff_log} + 6'(BSHIFT);
  end

  // Next-state for roles, ages, indices, word counter, drop counter and the ack pulse.
  always_comb begin
    role_d      = role_q;
    age_d       = age_q;
    read_idx_d  = read_idx_q;
    write_idx_d = write_idx_q;
    wr_count_d  = wr_count_q;
    drop_d      = drop_q;
    req_d       = SM_request;
    ack_d       = req_edge;
    fresh_d     = 1'b0;
    sel_found   = 1'b0;
    sel_idx     = '0;
    sel_age     = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    old_found   = 1'b0;
    old_idx     = '0;
    old_age     = '0;
    drop_inc    = '0;
    drop_sum    = '0;

    // Reader choice is made on the PENDING set as it stood before this edge,
    // so a buffer completing in the same cycle cannot be granted.
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (role_q[i] == ROLE_PENDING) begin
        if (!sel_found || (SM_mode ? (age_q[i] > sel_age) : (age_q[i] < sel_age))) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(i);
          sel_age   = age_q[i];
        end
      end
    end

    if (req_edge && sel_found) begin
      role_d[read_idx_q] = ROLE_FREE;
      role_d[sel_idx]    = ROLE_READ;
      read_idx_d         = sel_idx;
      fresh_d            = 1'b1;
    end

    if (WR_beat) begin
      if (wr_last) begin
        wr_count_d = '0;
        // Candidates see the buffer freed by a same-cycle request, but not
        // the ones LATEST mode is about to discard below.
        for (int i = 0; i < NUM_BUFFERS; i++) begin
          if (role_d[i] == ROLE_FREE && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
          end
          if (role_d[i] == ROLE_PENDING && (!old_found || age_q[i] > old_age)) begin
            old_found = 1'b1;
            old_idx   = IDX_W'(i);
            old_age   = age_q[i];
          end
        end
        // Surviving PENDING buffers age; LATEST mode discards them all as drops.
        for (int i = 0; i < NUM_BUFFERS; i++) begin
          if (role_d[i] == ROLE_PENDING) begin
            if (age_q[i] != '1) age_d[i] = age_q[i] + AGE_W'(1);
            if (!SM_mode) begin
              role_d[i] = ROLE_FREE;
              drop_inc  = drop_inc + CNT_W'(1);
            end
          end
        end
        role_d[write_idx_q] = ROLE_PENDING;
        age_d[write_idx_q]  = '0;
        if (free_found) begin
          write_idx_d = free_idx;
        end else begin
          // Out of space: the oldest PENDING frame is overwritten. In LATEST
          // mode it was already counted as a drop in the loop above.
          write_idx_d = old_idx;
          if (SM_mode) drop_inc = drop_inc + CNT_W'(1);
        end
        role_d[write_idx_d] = ROLE_WRITE;
        drop_sum = {1'b0, drop_q} + (DROP_WIDTH + 1)'(drop_inc);
        drop_d   = drop_sum[DROP_WIDTH] ? '1 : drop_sum[DROP_WIDTH-1:0];
      end else begin
        wr_count_d = wr_count_q + MAX_LOG_LENGTH'(1);
      end
    end

    // Soft reset silently discards everything, including the drop history.
    if (SM_clear) begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        role_d[i] = reset_role(i);
        age_d[i]  = '0;
      end
      read_idx_d  = '0;
      write_idx_d = IDX_W'(1);
      wr_count_d  = '0;
      drop_d      = '0;
      req_d       = 1'b0;
      ack_d       = 1'b0;
      fresh_d     = 1'b0;
    end
  end

  // State registers with asynchronous reset to the same state SM_clear produces.
  always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
    if (SYS_areset) begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        role_q[i] <= reset_role(i);
        age_q[i]  <= '0;
      end
      read_idx_q  <= '0;
      write_idx_q <= IDX_W'(1);
      wr_count_q  <= '0;
      drop_q      <= '0;
      req_q       <= 1'b0;
      ack_q       <= 1'b0;
      fresh_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        role_q[i] <= role_d[i];
        age_q[i]  <= age_d[i];
      end
      read_idx_q  <= read_idx_d;
      write_idx_q <= write_idx_d;
      wr_count_q  <= wr_count_d;
      drop_q      <= drop_d;
      req_q       <= req_d;
      ack_q       <= ack_d;
      fresh_q     <= fresh_d;
    end
  end

  // PENDING population, derived from the registered roles so it moves with them.
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (role_q[i] == ROLE_PENDING) pend_cnt = pend_cnt + CNT_W'(1);
    end
  end

  // Address generation, wrapping modulo the address width.
  always_comb begin
    SM_read_buffer   = SM_base_address + (MM_ADDR_WIDTH'(read_idx_q) << buf_shift);
    SM_write_address = SM_base_address + (MM_ADDR_WIDTH'(write_idx_q) << buf_shift)
                     + (MM_ADDR_WIDTH'(wr_count_q) << BSHIFT);
  end

  assign SM_ack           = ack_q;
  assign SM_fresh         = fresh_q;
  assign SM_read_index    = read_idx_q;
  assign SM_pending_count = pend_cnt;
  assign SM_drop_count    = drop_q;

endmodule

// File: tb/tb_multi_buffer_manager.sv
// Directed bench for multi_buffer_manager (N=4, 32-bit words, base 0x1000_0000).
module tb_multi_buffer_manager;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        SYS_aclk;
  logic        SYS_areset;
  logic        SM_clear;
  logic        SM_mode;
  logic [4:0]  SM_log_length;
  logic [31:0] SM_base_address;
  logic        SM_request;
  logic        WR_beat;
  logic        SM_ack;
  logic        SM_fresh;
  logic [1:0]  SM_read_index;
  logic [31:0] SM_read_buffer;
  logic [31:0] SM_write_address;
  logic [2:0]  SM_pending_count;
  logic [15:0] SM_drop_count;

  int errors = 0;
  int checks = 0;

  multi_buffer_manager #(
    .MM_ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_BUFFERS(4),
    .MAX_LOG_LENGTH(22), .DROP_WIDTH(16)
  ) dut (
    .SYS_aclk(SYS_aclk),
    .SYS_areset(SYS_areset),
    .SM_clear(SM_clear),
    .SM_mode(SM_mode),
    .SM_log_length(SM_log_length),
    .SM_base_address(SM_base_address),
    .SM_request(SM_request),
    .WR_beat(WR_beat),
    .SM_ack(SM_ack),
    .SM_fresh(SM_fresh),
    .SM_read_index(SM_read_index),
    .SM_read_buffer(SM_read_buffer),
    .SM_write_address(SM_write_address),
    .SM_pending_count(SM_pending_count),
    .SM_drop_count(SM_drop_count)
  );

  // Clock.
  initial SYS_aclk = 1'b0;
  always #5 SYS_aclk = ~SYS_aclk;

  typedef struct {
    logic       clear;
    logic       mode;
    logic [4:0] log_len;
    int         beats;
    logic       req;
    logic       ack;
    logic       fresh;
    int         ridx;
    int         widx;
    int         wr;
    int         pend;
    int         drop;
  } vec_t;

  vec_t vecs [17];

  task automatic tick();
    @(posedge SYS_aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] buf_addr(input int idx, input int wr, input logic [4:0] ll);
    return BASE + 32'((idx << ll) * 4) + 32'(wr * 4);
  endfunction

  task automatic check_state(input string tag, input logic ack, input logic fresh, input int ridx,
                             input int widx, input int wr, input int pend, input int drop,
                             input logic [4:0] ll);
    check({tag, " ack"},        32'(SM_ack), 32'(ack));
    check({tag, " fresh"},      32'(SM_fresh), 32'(fresh));
    check({tag, " read_index"}, 32'(SM_read_index), 32'(ridx));
    check({tag, " read_buf"},   SM_read_buffer, buf_addr(ridx, 0, ll));
    check({tag, " write_addr"}, SM_write_address, buf_addr(widx, wr, ll));
    check({tag, " pending"},    32'(SM_pending_count), 32'(pend));
    check({tag, " drops"},      32'(SM_drop_count), 32'(drop));
  endtask

  task automatic apply_vec(input int n, input vec_t v);
    if (v.clear) begin
      SM_clear = 1'b1;
      tick();
      SM_clear = 1'b0;
    end
    SM_mode       = v.mode;
    SM_log_length = v.log_len;
    for (int b = 0; b < v.beats; b++) begin
      WR_beat = 1'b1;
      tick();
    end
    WR_beat = 1'b0;
    if (v.req) begin
      SM_request = 1'b1;
      tick();
    end
    check_state($sformatf("row%0d", n), v.ack, v.fresh, v.ridx, v.widx, v.wr, v.pend, v.drop,
                v.log_len);
    if (v.req) begin
      SM_request = 1'b0;
      tick();
    end
  endtask

  initial begin
    //             clr mode log beats req  ack fr ridx widx wr pend drop
    vecs[0]  = '{1'b0, 1'b0, 5'd2, 3, 1'b0, 1'b0, 1'b0, 0, 1, 3, 0, 0}; // 3 beats into buffer 1
    vecs[1]  = '{1'b0, 1'b0, 5'd2, 1, 1'b0, 1'b0, 1'b0, 0, 2, 0, 1, 0}; // LATEST: buffer 1 done
    vecs[2]  = '{1'b0, 1'b0, 5'd2, 4, 1'b0, 1'b0, 1'b0, 0, 3, 0, 1, 1}; // buffer 2 done, 1 dropped
    vecs[3]  = '{1'b0, 1'b0, 5'd2, 4, 1'b0, 1'b0, 1'b0, 0, 1, 0, 1, 2}; // buffer 3 done, 2 dropped
    vecs[4]  = '{1'b0, 1'b0, 5'd2, 0, 1'b1, 1'b1, 1'b1, 3, 1, 0, 0, 2}; // newest granted
    vecs[5]  = '{1'b1, 1'b1, 5'd2, 0, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0}; // SM_clear
    vecs[6]  = '{1'b0, 1'b1, 5'd2, 8, 1'b0, 1'b0, 1'b0, 0, 3, 0, 2, 0}; // QUEUE: 1,2 pending
    vecs[7]  = '{1'b0, 1'b1, 5'd2, 0, 1'b1, 1'b1, 1'b1, 1, 3, 0, 1, 0}; // oldest first
    vecs[8]  = '{1'b0, 1'b1, 5'd2, 0, 1'b1, 1'b1, 1'b1, 2, 3, 0, 0, 0};
    vecs[9]  = '{1'b0, 1'b1, 5'd2, 0, 1'b1, 1'b1, 1'b0, 2, 3, 0, 0, 0}; // nothing pending
    vecs[10] = '{1'b1, 1'b1, 5'd2, 4, 1'b0, 1'b0, 1'b0, 0, 2, 0, 1, 0}; // QUEUE overrun run
    vecs[11] = '{1'b0, 1'b1, 5'd2, 4, 1'b0, 1'b0, 1'b0, 0, 3, 0, 2, 0};
    vecs[12] = '{1'b0, 1'b1, 5'd2, 4, 1'b0, 1'b0, 1'b0, 0, 1, 0, 2, 1};
    vecs[13] = '{1'b0, 1'b1, 5'd2, 4, 1'b0, 1'b0, 1'b0, 0, 2, 0, 2, 2};
    vecs[14] = '{1'b1, 1'b0, 5'd2, 3, 1'b0, 1'b0, 1'b0, 0, 1, 3, 0, 0}; // mid-buffer
    vecs[15] = '{1'b0, 1'b0, 5'd1, 1, 1'b0, 1'b0, 1'b0, 0, 2, 0, 1, 0}; // shrink: next beat completes
    vecs[16] = '{1'b0, 1'b0, 5'd1, 0, 1'b1, 1'b1, 1'b1, 1, 2, 0, 0, 0};

    // Reset.
    SYS_areset      = 1'b1;
    SM_clear        = 1'b0;
    SM_mode         = 1'b0;
    SM_log_length   = 5'd2;
    SM_base_address = BASE;
    SM_request      = 1'b0;
    WR_beat         = 1'b0;
    tick();
    tick();
    SYS_areset = 1'b0;
    tick();
    check_state("reset", 1'b0, 1'b0, 0, 1, 0, 0, 0, 5'd2);

    for (int i = 0; i < 17; i++) apply_vec(i, vecs[i]);

    // Request edge coinciding with a completion, one buffer pending.
    SM_clear = 1'b1;
    tick();
    SM_clear      = 1'b0;
    SM_mode       = 1'b1;
    SM_log_length = 5'd2;
    for (int b = 0; b < 7; b++) begin
      WR_beat = 1'b1;
      tick();
    end
    SM_request = 1'b1;
    tick();
    WR_beat = 1'b0;
    check_state("collide", 1'b1, 1'b1, 1, 0, 0, 1, 0, 5'd2);
    // Held-high request: no further acks.
    tick();
    check("held1 ack", 32'(SM_ack), 32'd0);
    tick();
    check("held2 ack", 32'(SM_ack), 32'd0);
    SM_request = 1'b0;
    tick();
    SM_request = 1'b1;
    tick();
    check_state("collide_next", 1'b1, 1'b1, 2, 0, 0, 0, 0, 5'd2);
    SM_request = 1'b0;
    tick();

    // Asynchronous reset mid-buffer with a frame pending and a drop recorded.
    SM_clear = 1'b1;
    tick();
    SM_clear = 1'b0;
    SM_mode  = 1'b0;
    for (int b = 0; b < 10; b++) begin
      WR_beat = 1'b1;
      tick();
    end
    WR_beat = 1'b0;
    check_state("pre_rst", 1'b0, 1'b0, 0, 3, 2, 1, 1, 5'd2);
    #2;
    SYS_areset = 1'b1;
    #1;
    check_state("in_rst", 1'b0, 1'b0, 0, 1, 0, 0, 0, 5'd2);
    tick();
    SYS_areset = 1'b0;
    tick();
    check_state("post_rst", 1'b0, 1'b0, 0, 1, 0, 0, 0, 5'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
